// File: rtl/register_bank.sv
// -----------------------------------------------------------------------------
// register_bank
// Register file for the 8-bit CPU datapath. It sits between the ALU result and
// the ALU operand muxes. It provides one write port from alu_out and two
// combinational read ports with same-cycle write bypass. It also keeps
// zero/negative result flags and a sequenced whole-bank clear.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   save        write enable (alu_out -> reg[wr_addr])
//   wr_addr     write address
//   alu_out     write data
//   rd_addr_a   read port A address
//   rd_addr_b   read port B address
//   data_out_a  read port A data (combinational)
//   data_out_b  read port B data (combinational)
//   clear       request a sequenced clear of the whole bank
//   busy        clear sequence in progress
//   wr_stall    one-cycle pulse: a save was dropped because busy was high
//   zero_flag   last accepted write data was zero
//   neg_flag    MSB of last accepted write data
// -----------------------------------------------------------------------------
module register_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int ZERO_REG   = 0,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  save,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic [DATA_WIDTH-1:0] data_out_b,
  input  logic                  clear,
  output logic                  busy,
  output logic                  wr_stall,
  output logic                  zero_flag,
  output logic                  neg_flag
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic [ADDR_WIDTH-1:0]   cnt_r;
  logic [DATA_WIDTH-1:0]   regs_r [NUM_REGS];
  logic                    busy_s;
  logic                    clr_en_s;
  logic                    last_s;
  logic                    wr_accept_s;
  logic                    wr_keep_s;
  logic                    wr_stall_r;
  logic                    zero_flag_r;
  logic                    neg_flag_r;
  logic [DATA_WIDTH-1:0]   data_a_s;
  logic [DATA_WIDTH-1:0]   data_b_s;

  // Read mux for one port. The hard-wired zero register wins over the bypass.
  // The bypass only applies while a write is actually being accepted.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  bypass_en,
    input logic [ADDR_WIDTH-1:0] waddr,
    input logic [DATA_WIDTH-1:0] wdata
  );
    logic [DATA_WIDTH-1:0] result;
    if ((ZERO_REG != 0) && (addr == '0)) begin
      result = '0;
    end else if (bypass_en && (addr == waddr)) begin
      result = wdata;
    end else begin
      result = stored;
    end
    return result;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic: clear pulses are only looked at while idle
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clear) begin
          next_state_s = ST_CLEAR;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_r == LAST_IDX) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_CLEAR;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    busy_s   = 1'b0;
    clr_en_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s   = 1'b0;
        clr_en_s = 1'b0;
      end
      ST_CLEAR: begin
        busy_s   = 1'b1;
        clr_en_s = 1'b1;
      end
      default: begin
        busy_s   = 1'b0;
        clr_en_s = 1'b0;
      end
    endcase
  end

  assign last_s      = clr_en_s && (cnt_r == LAST_IDX);
  assign wr_accept_s = save && !busy_s;
  // Writes to a hard-wired zero register are accepted (flags move) but not stored
  assign wr_keep_s   = wr_accept_s && !((ZERO_REG != 0) && (wr_addr == '0));

  // Clear index: walks 0..NUM_REGS-1 and parks at 0 so the next sequence starts there
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (clr_en_s) begin
      if (last_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + ADDR_WIDTH'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Register array: the clear sequence has priority, writes only land when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (clr_en_s) begin
      regs_r[cnt_r] <= '0;
    end else if (wr_keep_s) begin
      regs_r[wr_addr] <= alu_out;
    end
  end

  // Result flags and dropped-write pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_flag_r <= 1'b1;
      neg_flag_r  <= 1'b0;
      wr_stall_r  <= 1'b0;
    end else begin
      wr_stall_r <= save && busy_s;
      if (last_s) begin
        zero_flag_r <= 1'b1;
        neg_flag_r  <= 1'b0;
      end else if (wr_accept_s) begin
        zero_flag_r <= (alu_out == '0);
        neg_flag_r  <= alu_out[DATA_WIDTH-1];
      end else begin
        zero_flag_r <= zero_flag_r;
        neg_flag_r  <= neg_flag_r;
      end
    end
  end

  // Combinational read ports with write bypass
  always_comb begin
    data_a_s = read_port(rd_addr_a, regs_r[rd_addr_a], wr_accept_s, wr_addr, alu_out);
    data_b_s = read_port(rd_addr_b, regs_r[rd_addr_b], wr_accept_s, wr_addr, alu_out);
  end

  assign data_out_a = data_a_s;
  assign data_out_b = data_b_s;
  assign busy       = busy_s;
  assign wr_stall   = wr_stall_r;
  assign zero_flag  = zero_flag_r;
  assign neg_flag   = neg_flag_r;

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank. Two instances share all inputs: one with a normal
// register 0 and one with a hard-wired zero register 0. A behavioural model of
// the bank is compared against both on every falling clock edge. Directed
// literal checks follow the bring-up scenarios, then a randomized phase runs.
module tb_register_bank;

  localparam int DW = 8;
  localparam int NR = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          save;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] alu_out;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic          clear;

  logic [DW-1:0] a0, b0, a1, b1;
  logic          busy0, stall0, zero0, neg0;
  logic          busy1, stall1, zero1, neg1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  register_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .save(save), .wr_addr(wr_addr), .alu_out(alu_out),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .data_out_a(a0), .data_out_b(b0),
    .clear(clear), .busy(busy0), .wr_stall(stall0), .zero_flag(zero0), .neg_flag(neg0)
  );

  register_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ZERO_REG(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .save(save), .wr_addr(wr_addr), .alu_out(alu_out),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .data_out_a(a1), .data_out_b(b1),
    .clear(clear), .busy(busy1), .wr_stall(stall1), .zero_flag(zero1), .neg_flag(neg1)
  );

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_regs [NR];
  logic          m_busy;
  int            m_step;      // how many registers the running clear has wiped
  logic          m_zero;
  logic          m_neg;
  logic          m_stall;

  // Model of the bank, advanced once per clock edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NR; i++) m_regs[i] <= '0;
      m_busy  <= 1'b0;
      m_step  <= 0;
      m_zero  <= 1'b1;
      m_neg   <= 1'b0;
      m_stall <= 1'b0;
    end else begin
      m_stall <= save && m_busy;
      if (m_busy) begin
        m_regs[m_step] <= '0;
        if (m_step == NR - 1) begin
          m_busy <= 1'b0;
          m_step <= 0;
          m_zero <= 1'b1;
          m_neg  <= 1'b0;
        end else begin
          m_step <= m_step + 1;
        end
      end else begin
        if (save) begin
          m_regs[wr_addr] <= alu_out;
          m_zero <= (alu_out == 8'h00);
          m_neg  <= alu_out[DW-1];
        end
        if (clear) begin
          m_busy <= 1'b1;
          m_step <= 0;
        end
      end
    end
  end

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] addr, input bit zr);
    if (zr && addr == 3'd0) return 8'h00;
    if (save && !m_busy && addr == wr_addr) return alu_out;
    return m_regs[addr];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    chk("m_a0", {24'd0, a0}, {24'd0, exp_read(rd_addr_a, 1'b0)});
    chk("m_b0", {24'd0, b0}, {24'd0, exp_read(rd_addr_b, 1'b0)});
    chk("m_a1", {24'd0, a1}, {24'd0, exp_read(rd_addr_a, 1'b1)});
    chk("m_b1", {24'd0, b1}, {24'd0, exp_read(rd_addr_b, 1'b1)});
    chk("m_busy0", {31'd0, busy0}, {31'd0, m_busy});
    chk("m_busy1", {31'd0, busy1}, {31'd0, m_busy});
    chk("m_stall0", {31'd0, stall0}, {31'd0, m_stall});
    chk("m_stall1", {31'd0, stall1}, {31'd0, m_stall});
    chk("m_zero0", {31'd0, zero0}, {31'd0, m_zero});
    chk("m_zero1", {31'd0, zero1}, {31'd0, m_zero});
    chk("m_neg0", {31'd0, neg0}, {31'd0, m_neg});
    chk("m_neg1", {31'd0, neg1}, {31'd0, m_neg});
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    save = 1'b0; clear = 1'b0; wr_addr = '0; alu_out = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    save = 1'b1; wr_addr = a; alu_out = d;
    cyc();
    save = 1'b0;
  endtask

  // Read register k on port A of dut0 (save is low, so no bypass).
  task automatic rd_chk(input string name, input logic [AW-1:0] k, input logic [DW-1:0] exp);
    rd_addr_a = k;
    #1;
    chk(name, {24'd0, a0}, {24'd0, exp});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy0 && n < 40) begin
      cyc();
      n++;
    end
    chk(name, {31'd0, busy0}, 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int k;
    reset_n = 1'b0;
    idle_inputs();
    rd_addr_a = '0; rd_addr_b = '0;
    cyc(); cyc();

    // Reset state
    for (int i = 0; i < NR; i++) rd_chk("rst_read", AW'(i), 8'h00);
    chk("rst_zero", {31'd0, zero0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    reset_n = 1'b1;
    cyc();

    // Basic write and read-back
    wr(3'd3, 8'h5A);
    rd_chk("wr_5a", 3'd3, 8'h5A);
    chk("wr_5a_zero", {31'd0, zero0}, 32'd0);
    chk("wr_5a_neg", {31'd0, neg0}, 32'd0);

    // Bypass on both ports before the edge
    wr(3'd2, 8'h11);
    save = 1'b1; wr_addr = 3'd2; alu_out = 8'h80; rd_addr_a = 3'd2; rd_addr_b = 3'd2;
    #1;
    chk("byp_a", {24'd0, a0}, 32'h80);
    chk("byp_b", {24'd0, b0}, 32'h80);
    cyc();
    save = 1'b0;
    chk("byp_neg", {31'd0, neg0}, 32'd1);
    rd_chk("byp_after", 3'd2, 8'h80);

    // Hard-wired zero register
    rd_addr_a = 3'd0;
    save = 1'b1; wr_addr = 3'd0; alu_out = 8'hFF;
    #1;
    chk("zr_byp", {24'd0, a1}, 32'h00);
    cyc();
    save = 1'b0;
    #1;
    chk("zr_read", {24'd0, a1}, 32'h00);
    chk("zr_neg", {31'd0, neg1}, 32'd1);
    chk("nz_read", {24'd0, a0}, 32'hFF);
    wr(3'd5, 8'h00);
    chk("zr_zero", {31'd0, zero1}, 32'd1);

    // Clear sequence with a second clear mid-way
    for (int i = 0; i < NR; i++) wr(AW'(i), 8'h10 + 8'(i));
    rd_chk("fill7", 3'd7, 8'h17);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    k = 0;
    while (busy0 && k < 20) begin
      clear = (k == 3);
      rd_addr_a = AW'(k);
      cyc();
      clear = 1'b0;
      #1;
      chk("clr_walk", {24'd0, a0}, 32'h00);
      k++;
    end
    chk("clr_len", k, 32'd8);
    for (int i = 0; i < NR; i++) rd_chk("clr_all", AW'(i), 8'h00);
    chk("clr_zero", {31'd0, zero0}, 32'd1);

    // Write dropped during clear
    wr(3'd7, 8'h81);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    cyc();
    wr(3'd7, 8'h33);
    #1;
    chk("stall_hi", {31'd0, stall0}, 32'd1);
    chk("stall_flag", {31'd0, neg0}, 32'd1);
    cyc();
    chk("stall_lo", {31'd0, stall0}, 32'd0);
    wait_idle("stall_idle");
    rd_chk("stall_r7", 3'd7, 8'h00);

    // Same-cycle clear and save
    save = 1'b1; clear = 1'b1; wr_addr = 3'd1; alu_out = 8'h44;
    cyc();
    idle_inputs();
    rd_chk("cs_44", 3'd1, 8'h44);
    wait_idle("cs_idle");
    rd_chk("cs_0", 3'd1, 8'h00);

    // Reset in the middle of a clear
    wr(3'd6, 8'h66);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    cyc(); cyc(); cyc();
    reset_n = 1'b0;
    #1;
    chk("mid_busy", {31'd0, busy0}, 32'd0);
    rd_chk("mid_r6", 3'd6, 8'h00);
    cyc();
    reset_n = 1'b1;
    cyc();
    wr(3'd6, 8'h99);
    for (int i = 0; i < 10; i++) cyc();
    rd_chk("mid_99", 3'd6, 8'h99);
    chk("mid_nobusy", {31'd0, busy0}, 32'd0);

    // Randomized traffic, checked by the model process
    for (int i = 0; i < 400; i++) begin
      save      = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 15) == 0);
      wr_addr   = AW'($urandom_range(0, NR - 1));
      alu_out   = DW'($urandom);
      rd_addr_a = AW'($urandom_range(0, NR - 1));
      rd_addr_b = (i % 4 == 0) ? wr_addr : AW'($urandom_range(0, NR - 1));
      reset_n   = ($urandom_range(0, 79) != 0);
      cyc();
    end
    reset_n = 1'b1;
    idle_inputs();
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
